// File: rtl/stopwatch.sv
// Six-digit BCD stopwatch (MM:SS.hh) with a clock prescaler, level pause and
// asynchronous active-high clear.
module stopwatch #(
  parameter int unsigned TICK_DIV = 1
) (
  output logic [3:0] msh,
  output logic [3:0] msl,
  output logic [3:0] sh,
  output logic [3:0] sl,
  output logic [3:0] mh,
  output logic [3:0] ml,
  input  logic       clk,
  input  logic       clr,
  input  logic       pause
);

  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);
  localparam logic [3:0] MAX_9 = 4'd9;
  localparam logic [3:0] MAX_5 = 4'd5;

  logic [PRE_W-1:0] pre;
  logic             tick_c;
  logic [5:0]       carry_c;

  // Next BCD value; anything at or above the top value rolls to zero.
  function automatic logic [3:0] bcd_next(input logic [3:0] d, input logic [3:0] top);
    return (d >= top) ? 4'd0 : d + 4'd1;
  endfunction

  // Tick and ripple-carry enables: carry_c[i] advances digit i (msl first).
  always_comb begin
    carry_c    = '0;
    tick_c     = (pre == PRE_MAX) && !pause;
    carry_c[0] = tick_c;
    carry_c[1] = carry_c[0] && (msl >= MAX_9);
    carry_c[2] = carry_c[1] && (msh >= MAX_9);
    carry_c[3] = carry_c[2] && (sl  >= MAX_9);
    carry_c[4] = carry_c[3] && (sh  >= MAX_5);
    carry_c[5] = carry_c[4] && (ml  >= MAX_9);
  end

  // Prescaler holds while paused so a resume loses no partial tick.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      pre <= '0;
    end else if (!pause) begin
      pre <= tick_c ? '0 : pre + PRE_W'(1);
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      msl <= 4'd0;
      msh <= 4'd0;
      sl  <= 4'd0;
      sh  <= 4'd0;
      ml  <= 4'd0;
      mh  <= 4'd0;
    end else begin
      if (carry_c[0]) msl <= bcd_next(msl, MAX_9);
      if (carry_c[1]) msh <= bcd_next(msh, MAX_9);
      if (carry_c[2]) sl  <= bcd_next(sl,  MAX_9);
      if (carry_c[3]) sh  <= bcd_next(sh,  MAX_5);
      if (carry_c[4]) ml  <= bcd_next(ml,  MAX_9);
      if (carry_c[5]) mh  <= bcd_next(mh,  MAX_5);
    end
  end

endmodule

// File: tb/tb_stopwatch.sv
// Self-checking bench: two stopwatch instances (TICK_DIV 1 and 3) against an
// arithmetic model counting running edges since the last clear.
module tb_stopwatch;

  logic clk = 1'b0;
  logic clr;
  logic pause;
  logic [3:0] msh1, msl1, sh1, sl1, mh1, ml1;
  logic [3:0] msh3, msl3, sh3, sl3, mh3, ml3;

  int checks = 0;
  int errors = 0;
  int run = 0;
  int base1 = 0;

  stopwatch #(.TICK_DIV(1)) dut1 (
    .msh(msh1), .msl(msl1), .sh(sh1), .sl(sl1), .mh(mh1), .ml(ml1),
    .clk(clk), .clr(clr), .pause(pause)
  );

  stopwatch #(.TICK_DIV(3)) dut3 (
    .msh(msh3), .msl(msl3), .sh(sh3), .sl(sl3), .mh(mh3), .ml(ml3),
    .clk(clk), .clr(clr), .pause(pause)
  );

  always #10 clk = ~clk;

  // Model: count clock edges on which the watch is running.
  always @(posedge clk) begin
    if (!clr && !pause) run = run + 1;
  end

  // Display digits {mh,ml,sh,sl,msh,msl} for a hundredths count.
  function automatic logic [23:0] digits(input int v);
    int w, mm, ss, hh;
    w  = v % 360000;
    mm = w / 6000;
    ss = (w / 100) % 60;
    hh = w % 100;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), 4'(hh / 10), 4'(hh % 10)};
  endfunction

  task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] obs1();
    return {mh1, ml1, sh1, sl1, msh1, msl1};
  endfunction

  function automatic logic [23:0] obs3();
    return {mh3, ml3, sh3, sl3, msh3, msl3};
  endfunction

  task automatic check_all(input string tag);
    check({tag, "_div1"}, obs1(), digits(base1 + run));
    check({tag, "_div3"}, obs3(), digits(run / 3));
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    @(negedge clk);
    check_all(tag);
  endtask

  // Clear pulse placed between edges, checked while clr is still high.
  task automatic clr_pulse(input string tag);
    clr = 1'b1;
    run = 0;
    base1 = 0;
    #1;
    check({tag, "_clr1"}, obs1(), 24'h000000);
    check({tag, "_clr3"}, obs3(), 24'h000000);
    clr = 1'b0;
  endtask

  initial begin
    clr = 1'b1;
    pause = 1'b1;
    #55;
    clr = 1'b0;
    check_all("reset");
    #20;
    check_all("paused_hold");
    #20;                              // t=95
    pause = 1'b0;
    #100;                             // t=195: five running edges
    pause = 1'b1;
    #1;
    check("five_ticks", obs1(), 24'h000005);
    check_all("five_ticks_model");
    #39;                              // t=235
    check("pause_hold", obs1(), 24'h000005);
    pause = 1'b0;
    #41;                              // t=276: edges at 250, 270
    check("resume", obs1(), 24'h000007);
    check_all("resume_model");

    // 100 ticks from zero: hundredths roll into seconds
    @(negedge clk);
    pause = 1'b0;
    clr_pulse("pre100");
    repeat (100) cycle("run100");
    check("hundred", obs1(), 24'h000100);

    // 6000 ticks from zero: one minute
    clr_pulse("pre6000");
    repeat (6000) cycle("run6000");
    check("minute", obs1(), 24'h010000);

    // Preload dut1 to 59:59.99 while paused, then one tick wraps to zero
    pause = 1'b1;
    clr_pulse("prewrap");
    force dut1.mh = 4'd5;
    force dut1.ml = 4'd9;
    force dut1.sh = 4'd5;
    force dut1.sl = 4'd9;
    force dut1.msh = 4'd9;
    force dut1.msl = 4'd9;
    #1;
    release dut1.mh;
    release dut1.ml;
    release dut1.sh;
    release dut1.sl;
    release dut1.msh;
    release dut1.msl;
    base1 = 359999;
    #1;
    check("preload", obs1(), 24'h595999);
    pause = 1'b0;
    cycle("wrap");
    check("wrap_zero", obs1(), 24'h000000);
    repeat (37) cycle("after_wrap");
    @(posedge clk);
    #5;
    clr_pulse("mid_clr");
    @(negedge clk);
    check_all("post_clr");

    // Randomized pause/run segments with occasional mid-cycle clears
    for (int seg = 0; seg < 400; seg++) begin
      pause = ($urandom_range(0, 3) == 0);
      for (int k = 0; k < int'($urandom_range(1, 12)); k++) cycle("rand");
      if ($urandom_range(0, 25) == 0) begin
        @(posedge clk);
        #3;
        clr_pulse("rand_clr");
        @(negedge clk);
        check_all("rand_post_clr");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
